// File: rtl/branch_resolve_unit.sv
// Branch resolution in ID: operand forwarding, branch condition evaluation,
// a one-cycle load-use stall, a 2-bit branch history table for fetch-stage
// prediction, and saturating branch/mispredict statistics.
module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    input  logic              id_valid,
    input  logic [5:0]        id_opcode,
    input  logic [31:0]       id_pc,
    input  logic              id_pred_taken,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_read_rs,
    input  logic [DATA_W-1:0] id_read_rt,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [4:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_data,
    output logic [1:0]        pc_src,
    output logic              flush,
    output logic              stall,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BLEZ = 6'b000110;
    localparam logic [5:0] OP_BGTZ = 6'b000111;

    typedef enum logic {RESOLVE, STALL} state_t;

    state_t            state;
    state_t            next_state;
    logic [1:0]        bht [BHT_DEPTH];
    logic [IDX_W-1:0]  if_idx;
    logic [IDX_W-1:0]  id_idx;
    logic [DATA_W-1:0] op_rs;
    logic [DATA_W-1:0] op_rt;
    logic              is_jump;
    logic              is_cond;
    logic              uses_rt;
    logic              cond_taken;
    logic              load_use;
    logic              resolve;
    logic              mispredict;

    // Only the index bits of the PCs address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], id_pc[31:IDX_W+2], id_pc[1:0]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign id_idx = id_pc[IDX_W+1:2];

    // The lookup reads the registered entry, so a same-cycle update is not visible yet.
    assign pred_taken = bht[if_idx][1];

    assign is_jump = (id_opcode == OP_J);
    assign is_cond = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE) ||
                     (id_opcode == OP_BLEZ) || (id_opcode == OP_BGTZ);
    assign uses_rt = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);

    // A load in EX cannot forward its data yet, so it is skipped here and caught by load_use.
    assign op_rs = (ex_reg_write && !ex_mem_read && ex_rd == id_rs && id_rs != 5'd0) ? ex_alu_out :
                   (mem_reg_write && mem_rd == id_rs && id_rs != 5'd0)              ? mem_data   :
                                                                                      id_read_rs;
    assign op_rt = (ex_reg_write && !ex_mem_read && ex_rd == id_rt && id_rt != 5'd0) ? ex_alu_out :
                   (mem_reg_write && mem_rd == id_rt && id_rt != 5'd0)              ? mem_data   :
                                                                                      id_read_rt;

    // Evaluate the branch condition on the forwarded operands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cond_taken = 1'b0;
        case (id_opcode)
            OP_BEQ:  cond_taken = (op_rs == op_rt);
            OP_BNE:  cond_taken = (op_rs != op_rt);
            OP_BLEZ: cond_taken = op_rs[DATA_W-1] || (op_rs == '0);
            OP_BGTZ: cond_taken = !op_rs[DATA_W-1] && (op_rs != '0);
            default: cond_taken = 1'b0;
        endcase
    end

    // The stall is only raised from RESOLVE; in STALL the load has reached MEM.
    assign load_use = !rst && id_valid && is_cond && (state == RESOLVE) &&
                      ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (uses_rt && ex_rd == id_rt));

    assign resolve    = !rst && id_valid && is_cond && !load_use;
    assign mispredict = resolve && (cond_taken != id_pred_taken);

    // State register for the load-use stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) state <= RESOLVE;
        else     state <= next_state;
    end

    // Next-state and next-PC/flush/stall decode.
    always_comb begin
        next_state = state;
        pc_src     = 2'b00;
        flush      = 1'b0;
        stall      = 1'b0;
        case (state)
            RESOLVE: if (load_use) next_state = STALL;
            STALL:   next_state = RESOLVE;
            default: next_state = RESOLVE;
        endcase
        if (load_use) begin
            stall = 1'b1;
        end else if (mispredict) begin
            pc_src = cond_taken ? 2'b01 : 2'b11;
            flush  = 1'b1;
        end else if (!rst && id_valid && is_jump) begin
            pc_src = 2'b10;
            flush  = 1'b1;
        end
    end

    // Train the 2-bit saturating counter of each resolved conditional branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is flop-based and must start weakly not-taken, so every entry is reset.
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            if (cond_taken && bht[id_idx] != 2'b11)       bht[id_idx] <= bht[id_idx] + 2'b01;
            else if (!cond_taken && bht[id_idx] != 2'b00) bht[id_idx] <= bht[id_idx] - 2'b01;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve && branch_count != '1)        branch_count     <= branch_count + 1'b1;
            if (mispredict && mispredict_count != '1) mispredict_count <= mispredict_count + 1'b1;
        end
    end

endmodule
